min_sec_counter: RTL

//   Free-running minutes:seconds timekeeper for the DE2 labs. Divides CLOCK_50

---
 rtl/min_sec_counter_pkg.sv | 12 +
 rtl/min_sec_counter_tick_gen.sv | 32 +++
 rtl/min_sec_counter.sv | 84 ++++++++
 3 files changed

// File: rtl/min_sec_counter_pkg.sv
// Shared limits and helpers for the minutes:seconds timekeeper and its display stage.
package min_sec_counter_pkg;

  localparam logic [5:0] SEC_MAX = 6'd59;
  localparam logic [5:0] MIN_MAX = 6'd59;

  // Clamp a loaded value so SEC/MIN can never leave 0..59.
  function automatic logic [5:0] sat_load(input logic [5:0] v, input logic [5:0] lim);
    return (v > lim) ? lim : v;
  endfunction

endpackage

// File: rtl/min_sec_counter_tick_gen.sv
// Prescaler: counts 0..TICK_DIV-1 while enabled and flags the terminal count.
module tick_gen #(
  parameter int TICK_DIV = 50_000_000,
  parameter int DIV_W    = 26
) (
  input  logic CLOCK_50,
  input  logic Resetn,
  input  logic En,
  input  logic Zero,
  output logic Tick
);

  localparam logic [DIV_W-1:0] TC = DIV_W'(TICK_DIV - 1);

  logic [DIV_W-1:0] r_cnt;
  logic             w_tc;

  assign w_tc = (r_cnt == TC);
  // Combinational so the owner can update on the same edge the prescaler wraps.
  assign Tick = En & w_tc;

  always_ff @(posedge CLOCK_50 or negedge Resetn) begin
    if (!Resetn) begin
      r_cnt <= '0;
    end else if (Zero) begin
      r_cnt <= '0;
    end else if (En) begin
      r_cnt <= w_tc ? '0 : r_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/min_sec_counter.sv
// Free-running MIN:SEC binary timekeeper driven by a 1 Hz tick derived from CLOCK_50.
module min_sec_counter
  import min_sec_counter_pkg::*;
#(
  parameter int TICK_DIV = 50_000_000,
  parameter int DIV_W    = 26
) (
  input  logic       CLOCK_50,
  input  logic       Resetn,
  input  logic       Run,
  input  logic       Clear,
  input  logic       Load,
  input  logic [5:0] LoadSec,
  input  logic [5:0] LoadMin,
  output logic [5:0] SEC,
  output logic [5:0] MIN,
  output logic       TICK,
  output logic       ROLL
);

  logic       w_tick;
  logic       w_zero;
  logic [5:0] r_sec;
  logic [5:0] r_min;
  logic       r_tick;
  logic       r_roll;

  assign w_zero = Clear | Load;

  tick_gen #(
    .TICK_DIV(TICK_DIV),
    .DIV_W   (DIV_W)
  ) u_tick_gen (
    .CLOCK_50(CLOCK_50),
    .Resetn  (Resetn),
    .En      (Run),
    .Zero    (w_zero),
    .Tick    (w_tick)
  );

  // Clear beats Load beats the tick; a tick coinciding with Load is dropped.
  always_ff @(posedge CLOCK_50 or negedge Resetn) begin
    if (!Resetn) begin
      r_sec  <= '0;
      r_min  <= '0;
      r_tick <= 1'b0;
      r_roll <= 1'b0;
    end else if (Clear) begin
      r_sec  <= '0;
      r_min  <= '0;
      r_tick <= 1'b0;
      r_roll <= 1'b0;
    end else if (Load) begin
      r_sec  <= sat_load(LoadSec, SEC_MAX);
      r_min  <= sat_load(LoadMin, MIN_MAX);
      r_tick <= 1'b0;
      r_roll <= 1'b0;
    end else if (w_tick) begin
      r_tick <= 1'b1;
      if (r_sec == SEC_MAX) begin
        r_sec <= '0;
        if (r_min == MIN_MAX) begin
          r_min  <= '0;
          r_roll <= 1'b1;
        end else begin
          r_min  <= r_min + 6'd1;
          r_roll <= 1'b0;
        end
      end else begin
        r_sec  <= r_sec + 6'd1;
        r_roll <= 1'b0;
      end
    end else begin
      r_tick <= 1'b0;
      r_roll <= 1'b0;
    end
  end

  assign SEC  = r_sec;
  assign MIN  = r_min;
  assign TICK = r_tick;
  assign ROLL = r_roll;

endmodule
